// File: rtl/tm1638_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_frame_ctrl
// Brief    : Sends three BCD digits and a brightness level to a TM1638 as one
//            three-transaction serial frame (stb/sclk/dio, LSB first).
// Revision : 1.0
// ============================================================================
module tm1638_frame_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bcd_in,
  input  logic [2:0]  brightness,
  output logic        stb,
  output logic        sclk,
  output logic        dio,
  output logic        busy,
  output logic        done
);

  localparam int                 c_DIV_W     = $clog2(2 * CLK_DIV);
  localparam logic [c_DIV_W-1:0] c_HALF_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_GAP_LAST  = c_DIV_W'(2 * CLK_DIV - 1);
  localparam logic [7:0]         c_T1_CMD    = 8'h40;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SHIFT_LOW  = 3'd1,
    S_SHIFT_HIGH = 3'd2,
    S_GAP        = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_DIV_W-1:0] r_div;
  logic [2:0]         r_bit;
  logic [2:0]         r_byte;
  logic [1:0]         r_txn;
  logic [11:0]        r_bcd;
  logic [2:0]         r_bright;

  logic       w_last_bit;
  logic [2:0] w_nbit;
  logic [2:0] w_nbyte;
  logic [7:0] w_next_byte;
  logic [7:0] w_txn_first;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // T1 = auto-increment write, T2 = address 0 + digit/LED pairs, T3 = display on
  function automatic logic [7:0] frame_byte(input logic [1:0]  txn,
                                            input logic [2:0]  idx,
                                            input logic [11:0] bcd,
                                            input logic [2:0]  br);
    frame_byte = 8'h00;
    case (txn)
      2'd0: frame_byte = c_T1_CMD;
      2'd1: begin
        case (idx)
          3'd0:    frame_byte = 8'hC0;
          3'd1:    frame_byte = seg7(bcd[11:8]);
          3'd3:    frame_byte = seg7(bcd[7:4]);
          3'd5:    frame_byte = seg7(bcd[3:0]);
          default: frame_byte = 8'h00;
        endcase
      end
      default: frame_byte = {5'b10001, br};
    endcase
  endfunction

  always_comb begin
    w_last_bit  = (r_bit == 3'd7) && (r_byte == ((r_txn == 2'd1) ? 3'd6 : 3'd0));
    w_nbit      = r_bit + 3'd1;
    w_nbyte     = (r_bit == 3'd7) ? (r_byte + 3'd1) : r_byte;
    w_next_byte = frame_byte(r_txn, w_nbyte, r_bcd, r_bright);
    w_txn_first = frame_byte(r_txn + 2'd1, 3'd0, r_bcd, r_bright);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_txn    <= '0;
      r_bcd    <= '0;
      r_bright <= '0;
      stb      <= 1'b1;
      sclk     <= 1'b1;
      dio      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        // DONE already has busy low, so a start there begins the next frame
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (start) begin
            r_state  <= S_SHIFT_LOW;
            r_bcd    <= bcd_in;
            r_bright <= brightness;
            r_div    <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_txn    <= '0;
            stb      <= 1'b0;
            sclk     <= 1'b0;
            dio      <= c_T1_CMD[0];
            busy     <= 1'b1;
          end
        end
        S_SHIFT_LOW: begin
          if (r_div == c_HALF_LAST) begin
            r_div   <= '0;
            sclk    <= 1'b1;
            r_state <= S_SHIFT_HIGH;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_SHIFT_HIGH: begin
          if (r_div == c_HALF_LAST) begin
            r_div <= '0;
            if (w_last_bit) begin
              r_state <= S_GAP;
              stb     <= 1'b1;
              dio     <= 1'b1;
            end else begin
              r_bit   <= w_nbit;
              r_byte  <= w_nbyte;
              sclk    <= 1'b0;
              dio     <= w_next_byte[w_nbit];
              r_state <= S_SHIFT_LOW;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_GAP: begin
          if (r_div == c_GAP_LAST) begin
            r_div <= '0;
            if (r_txn == 2'd2) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_txn   <= r_txn + 2'd1;
              r_bit   <= '0;
              r_byte  <= '0;
              stb     <= 1'b0;
              sclk    <= 1'b0;
              dio     <= w_txn_first[0];
              r_state <= S_SHIFT_LOW;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
